// File: rtl/counter_capture_pkg.sv
// Shared constants and helpers for the counter capture stage: EDGE mode
// names, a constant clog2 and the FIFO level width derivation.
package counter_capture_pkg;

   localparam string EDGE_RISING  = "RISING";
   localparam string EDGE_FALLING = "FALLING";
   localparam string EDGE_BOTH    = "BOTH";

   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result    = result + 1;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

   // level must hold 0..depth inclusive, hence one bit more than the pointers
   function automatic int level_width(input int depth);
      return clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous first-word-fall-through FIFO holding captured counter words.
// Push into a full FIFO is only legal together with a pop; pop needs valid.
module capture_fifo
   import counter_capture_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [DATA_WIDTH-1:0]         wdata,
   input  logic                          pop,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic                          valid,
   output logic                          full,
   output logic [level_width(DEPTH)-1:0] level
);

   localparam int AW = clog2(DEPTH);
   localparam int LW = level_width(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [LW-1:0]         level_q;

   // Storage carries no reset; the head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            level_q <= level_q + LW'(1);
         end else if (pop && !push) begin
            level_q <= level_q - LW'(1);
         end
      end
   end

   assign valid = (level_q != '0);
   assign full  = (level_q == LW'(DEPTH));
   assign level = level_q;
   assign rdata = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/counter_capture.sv
// Snapshots count_in on a synchronised event edge and buffers it for a
// valid/ready consumer. Define COUNTER_CAPTURE_DELTA_EN to store deltas.
module counter_capture
   import counter_capture_pkg::*;
#(
   parameter int    DATA_WIDTH  = 8,
   parameter int    DEPTH       = 4,
   parameter int    SYNC_STAGES = 2,
   parameter string EDGE        = "RISING"
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_WIDTH-1:0]         count_in,
   input  logic                          event_in,
   input  logic                          cap_en,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [level_width(DEPTH)-1:0] level,
   output logic                          overflow,
   input  logic                          clr_ovf
);

   localparam bit DET_RISE = (EDGE == EDGE_RISING) || (EDGE == EDGE_BOTH);
   localparam bit DET_FALL = (EDGE == EDGE_FALLING) || (EDGE == EDGE_BOTH);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   sync_last;
   logic                   edge_det;
   logic                   capture;
   logic                   fifo_full;
   logic                   push;
   logic                   pop;
   logic                   drop;
   logic [DATA_WIDTH-1:0]  wdata;

   // Reset leaves prev at 0, so an input already high at release reads as a rise.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], event_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync_last = sync_q[SYNC_STAGES-1];
   assign edge_det  = (DET_RISE && sync_last && !prev_q) ||
                      (DET_FALL && !sync_last && prev_q);
   assign capture   = edge_det && cap_en;
   assign pop       = out_valid && out_ready;
   assign push      = capture && (!fifo_full || pop);
   assign drop      = capture && fifo_full && !pop;

`ifdef COUNTER_CAPTURE_DELTA_EN
   logic [DATA_WIDTH-1:0] ref_q;

   // Reference follows accepted pushes only, so drops never skew the next delta.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ref_q <= '0;
      end else if (push) begin
         ref_q <= count_in;
      end
   end

   assign wdata = count_in - ref_q;
`else
   assign wdata = count_in;
`endif

   // A drop in the same cycle as clr_ovf wins so no loss goes unreported.
   always_ff @(posedge clk) begin
      if (!rst) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

   capture_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (wdata),
      .pop   (pop),
      .rdata (out_data),
      .valid (out_valid),
      .full  (fifo_full),
      .level (level)
   );

endmodule

// File: tb/tb_counter_capture.sv
// Scoreboard bench for counter_capture: the counter advances every clock and
// each event pulse predicts its captured word. Honours COUNTER_CAPTURE_DELTA_EN.
module tb_counter_capture;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int SYNC  = 2;

   logic          clk;
   logic          rst;
   logic [DW-1:0] count_in;
   logic          event_in;
   logic          cap_en;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic [2:0]    level;
   logic          overflow;
   logic          clr_ovf;

   int            asserts_done;
   int            failures;
   logic [DW-1:0] sb [$];
   logic [DW-1:0] ref_model;

   counter_capture #(
      .DATA_WIDTH  (DW),
      .DEPTH       (DEPTH),
      .SYNC_STAGES (SYNC),
      .EDGE        ("RISING")
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .count_in  (count_in),
      .event_in  (event_in),
      .cap_en    (cap_en),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      asserts_done++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge; the counter
   // advances once per clock like the upstream counter.
   task automatic tick();
      @(negedge clk);
      count_in = count_in + 8'd1;
   endtask

   // The capture cycle falls SYNC clocks after the raise, so the sampled count
   // is the value at the raise plus SYNC.
   task automatic applyStimulus(input bit accept, input bit pop_at_capture,
                                input bit clr_at_capture);
      logic [DW-1:0] abs_val;
      abs_val  = count_in + 8'(SYNC);
      event_in = 1'b1;
      if (accept) begin
`ifdef COUNTER_CAPTURE_DELTA_EN
         sb.push_back(abs_val - ref_model);
         ref_model = abs_val;
`else
         sb.push_back(abs_val);
`endif
      end
      for (int i = 0; i < SYNC; i++) tick();
      if (pop_at_capture) begin
         checkOutput("pop_at_capture_head", out_data, sb[0]);
         void'(sb.pop_front());
         out_ready = 1'b1;
      end
      clr_ovf = clr_at_capture;
      tick();
      out_ready = 1'b0;
      clr_ovf   = 1'b0;
      event_in  = 1'b0;
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic drain();
      while (sb.size() > 0) begin
         checkOutput("drain_valid", out_valid, 1'b1);
         checkOutput("drain_data", out_data, sb[0]);
         void'(sb.pop_front());
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
      checkOutput("drain_empty", out_valid, 1'b0);
      checkOutput("drain_level", level, 3'd0);
   endtask

   initial begin
      asserts_done = 0;
      failures     = 0;
      ref_model    = '0;
      rst          = 1'b0;
      count_in     = 8'h00;
      event_in     = 1'b0;
      cap_en       = 1'b1;
      out_ready    = 1'b0;
      clr_ovf      = 1'b0;
      repeat (3) tick();
      checkOutput("reset_valid", out_valid, 1'b0);
      checkOutput("reset_level", level, 3'd0);
      checkOutput("reset_overflow", overflow, 1'b0);
      checkOutput("reset_data", out_data, 8'h00);
      rst = 1'b1;
      tick();

      // First capture from count 0x10
      count_in = 8'h10;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("first_valid", out_valid, 1'b1);
      checkOutput("first_level", level, 3'd1);
      checkOutput("first_data", out_data, 8'h10 + 8'(SYNC));
      drain();

      // Fill to DEPTH, then a fifth capture is dropped
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("full_level", level, 3'd4);
      checkOutput("full_no_overflow", overflow, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("drop_level", level, 3'd4);
      checkOutput("drop_overflow", overflow, 1'b1);
      drain();
      checkOutput("overflow_sticky", overflow, 1'b1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      checkOutput("overflow_cleared", overflow, 1'b0);

      // Capture into a full FIFO while the consumer pops in the same cycle
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("pushpop_level", level, 3'd4);
      checkOutput("pushpop_overflow", overflow, 1'b0);
      drain();

      // Edges with cap_en low are discarded
      cap_en = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      cap_en = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("capen_level", level, 3'd1);

      // Set beats clear when a drop coincides with clr_ovf
      for (int i = 1; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("ovf_set", overflow, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("ovf_set_beats_clear", overflow, 1'b1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      checkOutput("ovf_clear_alone", overflow, 1'b0);
      drain();

      // Reset mid-stream discards buffered words and the delta reference
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("prereset_level", level, 3'd2);
      rst = 1'b0;
      tick();
      checkOutput("midreset_valid", out_valid, 1'b0);
      checkOutput("midreset_level", level, 3'd0);
      checkOutput("midreset_data", out_data, 8'h00);
      sb.delete();
      ref_model = '0;
      rst = 1'b1;
      tick();

      // Captures at 0xF0 then 0x05 exercise the modulo wrap of the delta
      count_in = 8'hF0 - 8'(SYNC);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("wrap_first", out_data, 8'hF0);
      count_in = 8'h05 - 8'(SYNC);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("wrap_level", level, 3'd2);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", asserts_done, failures);
      $finish;
   end

endmodule
